// File: rtl/memory_stage.sv
// Memory pipeline stage of the RISC-V core.
// Holds the EX/MEM and MEM/WB registers, steers byte lanes for loads and
// stores, and waits on a slow data memory with a bounded IDLE/WAIT handshake.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of silently aligning them.
module memory_stage #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  Funct3E,
  input  logic [4:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        BusErrM,
  output logic        MisalignM
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] CntLast = 8'(WAIT_MAX - 1);

  logic        regWriteM_q, memWriteM_q;
  logic [1:0]  resultSrcM_q;
  logic [2:0]  funct3M_q;
  logic [4:0]  rdM_q;
  logic [31:0] aluResultM_q, writeDataM_q, pcPlus4M_q;

  logic [0:0]  state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;

  logic        regWriteW_q, regWriteW_d;
  logic [1:0]  resultSrcW_q;
  logic [4:0]  rdW_q;
  logic [31:0] aluResultW_q, readDataW_q, readDataW_d, pcPlus4W_q;

  logic        isAccess, badFunct3, sizeH, sizeW, trapMisalign;
  logic        memOp, timeout, stall, storeOp;
  logic [1:0]  offset, laneOffset;
  logic [3:0]  storeBe;
  logic [31:0] storeData;
  logic [15:0] laneHalf;

  // Classify the instruction in M and pick the byte lane it touches.
  always_comb begin
    isAccess  = memWriteM_q | (resultSrcM_q == 2'b01);
    badFunct3 = (funct3M_q == 3'b011) || (funct3M_q == 3'b110) || (funct3M_q == 3'b111);
    sizeH     = (funct3M_q[1:0] == 2'b01);
    sizeW     = (funct3M_q[1:0] == 2'b10);
    offset    = aluResultM_q[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    trapMisalign = isAccess & ~badFunct3 & ((sizeH & offset[0]) | (sizeW & (offset != 2'b00)));
    laneOffset   = offset;
`else
    trapMisalign = 1'b0;
    laneOffset   = sizeW ? 2'b00 : (sizeH ? {offset[1], 1'b0} : offset);
`endif
    memOp   = isAccess & ~badFunct3 & ~trapMisalign;
    storeOp = memOp & memWriteM_q;
    timeout = memOp & ~dmem_ready & (waitCnt_q == CntLast);
    stall   = memOp & ~dmem_ready & ~timeout;
  end

  // Store lane enables and replicated write data.
  always_comb begin
    storeBe   = 4'b1111;
    storeData = writeDataM_q;
    case (funct3M_q[1:0])
      2'b00: begin
        storeBe   = 4'b0001 << laneOffset;
        storeData = {4{writeDataM_q[7:0]}};
      end
      2'b01: begin
        storeBe   = 4'b0011 << {laneOffset[1], 1'b0};
        storeData = {2{writeDataM_q[15:0]}};
      end
      default: begin
        storeBe   = 4'b1111;
        storeData = writeDataM_q;
      end
    endcase
  end

  // Load data extraction with sign or zero extension.
  always_comb begin
    laneHalf    = 16'(dmem_rdata >> {laneOffset, 3'b000});
    readDataW_d = 32'h0;
    case (funct3M_q)
      3'b000:  readDataW_d = {{24{laneHalf[7]}}, laneHalf[7:0]};
      3'b001:  readDataW_d = {{16{laneHalf[15]}}, laneHalf};
      3'b010:  readDataW_d = dmem_rdata;
      3'b100:  readDataW_d = {24'h0, laneHalf[7:0]};
      3'b101:  readDataW_d = {16'h0, laneHalf};
      default: readDataW_d = 32'h0;
    endcase
    regWriteW_d = regWriteM_q & ~stall & ~timeout & ~trapMisalign & ~(isAccess & badFunct3);
  end

  // Wait-state FSM: any cycle still stalled moves to WAIT and counts, otherwise back to IDLE with a cleared counter.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    if (stall) begin
      state_d   = S_WAIT;
      waitCnt_d = waitCnt_q + 8'd1;
    end else begin
      state_d   = S_IDLE;
      waitCnt_d = 8'd0;
    end
  end

  // FSM and wait counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      waitCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // EX/MEM register, frozen while the memory stage is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteM_q  <= 1'b0;
      memWriteM_q  <= 1'b0;
      resultSrcM_q <= 2'b00;
      funct3M_q    <= 3'b000;
      rdM_q        <= 5'd0;
      aluResultM_q <= 32'h0;
      writeDataM_q <= 32'h0;
      pcPlus4M_q   <= 32'h0;
    end else if (!stall) begin
      regWriteM_q  <= RegWriteE;
      memWriteM_q  <= MemWriteE;
      resultSrcM_q <= ResultSrcE;
      funct3M_q    <= Funct3E;
      rdM_q        <= RdE;
      aluResultM_q <= ALUResultE;
      writeDataM_q <= WriteDataE;
      pcPlus4M_q   <= PCPlus4E;
    end
  end

  // MEM/WB register, loaded every cycle; a stall or failed access becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteW_q  <= 1'b0;
      resultSrcW_q <= 2'b00;
      rdW_q        <= 5'd0;
      aluResultW_q <= 32'h0;
      readDataW_q  <= 32'h0;
      pcPlus4W_q   <= 32'h0;
    end else begin
      regWriteW_q  <= regWriteW_d;
      resultSrcW_q <= resultSrcM_q;
      rdW_q        <= rdM_q;
      aluResultW_q <= aluResultM_q;
      readDataW_q  <= readDataW_d;
      pcPlus4W_q   <= pcPlus4M_q;
    end
  end

  assign StallM     = stall;
  assign BusErrM    = timeout;
  assign MisalignM  = trapMisalign;
  assign dmem_req   = memOp;
  assign dmem_we    = storeOp;
  assign dmem_addr  = {aluResultM_q[31:2], 2'b00};
  assign dmem_be    = storeOp ? storeBe : 4'b0000;
  assign dmem_wdata = storeOp ? storeData : 32'h0;
  assign ALUResultM = aluResultM_q;
  assign RdM        = rdM_q;
  assign RegWriteM  = regWriteM_q;
  assign RegWriteW  = regWriteW_q;
  assign ResultSrcW = resultSrcW_q;
  assign RdW        = rdW_q;
  assign ALUResultW = aluResultW_q;
  assign ReadDataW  = readDataW_q;
  assign PCPlus4W   = pcPlus4W_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed corner cases followed by
// random loads, stores and ALU ops, each checked against a byte-lane model.
module tb_memory_stage;

  localparam int WaitMax = 15;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic [4:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [31:0] ALUResultM;
  logic [4:0]  RdM;
  logic        RegWriteM, StallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic        BusErrM, MisalignM;

  int compCount = 0;
  int failCount = 0;

  memory_stage #(.WAIT_MAX(WaitMax)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .Funct3E(Funct3E), .RdE(RdE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .StallM(StallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .BusErrM(BusErrM), .MisalignM(MisalignM)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic driveBubble();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 2'b00; Funct3E = 3'b000;
    RdE = 5'd0; ALUResultE = 32'h0; WriteDataE = 32'h0; PCPlus4E = 32'h0;
  endtask

  // Access width in bytes implied by funct3 (0 for unused encodings).
  function automatic int sizeOf(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Issues one instruction at a negedge and follows it through M and W.
  task automatic applyStimulus(input logic regWrite, input logic memWrite, input logic [1:0] resultSrc,
                               input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] pc4,
                               input int readyDelay, input logic [31:0] rdata);
    bit       isLoad, isAccess, badOp, misal, expReq, expMis, expErr, expStall, expWrite, done;
    int       n, off;
    logic [3:0]  expBe;
    logic [31:0] expWdata, expLoad;
    longint   val;

    isLoad   = (resultSrc == 2'b01);
    isAccess = memWrite || isLoad;
    n        = sizeOf(f3);
    badOp    = isAccess && (n == 0 || (memWrite && f3[2]));
    if (memWrite && !badOp) n = sizeOf({1'b0, f3[1:0]});
    off      = int'(addr % 4);
    misal    = isAccess && !badOp && n > 1 && (off % n) != 0;
    expMis   = Trap && misal;
    expReq   = isAccess && !badOp && !expMis;
    if (!Trap) off = off - (off % n > 0 ? off % n : 0);

    expBe = 4'b0000; expWdata = 32'h0;
    if (expReq && memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) expBe[i] = 1'b1;
        expWdata[i*8 +: 8] = wdata[(i % n)*8 +: 8];
      end
    end
    val = 0;
    for (int k = 0; k < n && k < 4; k++)
      val = val + (longint'(rdata[(off + k)*8 +: 8]) << (8*k));
    if (!f3[2] && n < 4 && n > 0 && val >= (longint'(1) << (8*n - 1)))
      val = val - (longint'(1) << (8*n));
    expLoad = val[31:0];

    RegWriteE = regWrite; MemWriteE = memWrite; ResultSrcE = resultSrc; Funct3E = f3;
    RdE = rd; ALUResultE = addr; WriteDataE = wdata; PCPlus4E = pc4;
    @(posedge clk);
    @(negedge clk);
    driveBubble();
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      dmem_ready = (c >= readyDelay);
      dmem_rdata = rdata;
      #1;
      expStall = expReq && c < readyDelay && c < WaitMax - 1;
      expErr   = expReq && c < readyDelay && c == WaitMax - 1;
      if (c == 0) begin
        checkOutput("ALUResultM", ALUResultM, addr);
        checkOutput("RdM", 32'(RdM), 32'(rd));
        checkOutput("RegWriteM", 32'(RegWriteM), 32'(regWrite));
        checkOutput("MisalignM", 32'(MisalignM), 32'(expMis));
      end
      checkOutput("dmem_req", 32'(dmem_req), 32'(expReq));
      checkOutput("StallM", 32'(StallM), 32'(expStall));
      checkOutput("BusErrM", 32'(BusErrM), 32'(expErr));
      if (expReq) begin
        checkOutput("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        checkOutput("dmem_we", 32'(dmem_we), 32'(memWrite));
        checkOutput("dmem_be", 32'(dmem_be), 32'(expBe));
        checkOutput("dmem_wdata", dmem_wdata, expWdata);
      end
      @(posedge clk);
      #1;
      if (expStall) begin
        checkOutput("bubbleRegWriteW", 32'(RegWriteW), 32'h0);
        @(negedge clk);
      end else begin
        expWrite = regWrite && !badOp && !expMis && !expErr;
        checkOutput("RegWriteW", 32'(RegWriteW), 32'(expWrite));
        checkOutput("RdW", 32'(RdW), 32'(rd));
        checkOutput("ALUResultW", ALUResultW, addr);
        checkOutput("PCPlus4W", PCPlus4W, pc4);
        checkOutput("ResultSrcW", 32'(ResultSrcW), 32'(resultSrc));
        if (isLoad && expReq && !expErr) checkOutput("ReadDataW", ReadDataW, expLoad);
        done = 1;
      end
    end
    if (!done) checkOutput("cycleBudget", 32'h0, 32'h1);
    dmem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] f3;
    int kind;
    rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    driveBubble();
    #23;
    checkOutput("rstReq", 32'(dmem_req), 32'h0);
    checkOutput("rstStall", 32'(StallM), 32'h0);
    checkOutput("rstRegWriteW", 32'(RegWriteW), 32'h0);
    checkOutput("rstALUResultM", ALUResultM, 32'h0);
    checkOutput("rstReadDataW", ReadDataW, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW 0x100 zero-wait
    applyStimulus(1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF, 32'h44, 0, 32'h0);
    // LB 0x203 after three wait cycles
    applyStimulus(1'b1, 1'b0, 2'b01, 3'b000, 5'd7, 32'h203, 32'h0, 32'h48, 3, 32'h80FF7F01);
    // SH 0x12
    applyStimulus(1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h12, 32'h0000ABCD, 32'h4C, 0, 32'h0);
    // load that never completes -> bus error
    applyStimulus(1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h300, 32'h0, 32'h50, 1000, 32'h12345678);
    // LW 0x102 misaligned
    applyStimulus(1'b1, 1'b0, 2'b01, 3'b010, 5'd3, 32'h102, 32'h0, 32'h54, 0, 32'hCAFEF00D);
    // invalid funct3 load
    applyStimulus(1'b1, 1'b0, 2'b01, 3'b011, 5'd4, 32'h400, 32'h0, 32'h58, 0, 32'h1);

    // reset asserted while waiting
    RegWriteE = 1; MemWriteE = 0; ResultSrcE = 2'b01; Funct3E = 3'b010;
    RdE = 5'd5; ALUResultE = 32'h40; WriteDataE = 32'h0; PCPlus4E = 32'h5C;
    dmem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    driveBubble();
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("waitStall", 32'(StallM), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstWaitReq", 32'(dmem_req), 32'h0);
    checkOutput("rstWaitStall", 32'(StallM), 32'h0);
    checkOutput("rstWaitRegWriteM", 32'(RegWriteM), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rstHoldReq", 32'(dmem_req), 32'h0);
    checkOutput("rstHoldRegWriteW", 32'(RegWriteW), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b01, 3'b100, 5'd6, 32'h41, 32'h0, 32'h60, 1, 32'h00C30000);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        f3 = 3'($urandom_range(0, 2));
        applyStimulus(1'b0, 1'b1, 2'b00, f3, 5'd0, $urandom, $urandom, $urandom, $urandom_range(0, 3), 32'h0);
      end else if (kind < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
        applyStimulus(1'b1, 1'b0, 2'b01, f3, 5'($urandom), $urandom, 32'h0, $urandom,
                      (kind == 7) ? 20 : $urandom_range(0, 3), $urandom);
      end else begin
        applyStimulus(1'b1, 1'b0, (kind == 8) ? 2'b00 : 2'b10, 3'($urandom), 5'($urandom),
                      $urandom, $urandom, $urandom, 0, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter: WAIT_MAX, 15, maximum dmem wait cycles before bus error (range 1..255).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: RegWriteE, MemWriteE  in  1  control from execute.
REQ-005 SHALL have ports: ResultSrcE  in  2; Funct3E  in  3; RdE  in  5  (01 = load; Funct3 selects size).
REQ-006 SHALL have ports: ALUResultE, WriteDataE, PCPlus4E  in  32  execute results.
REQ-007 SHALL have ports: ALUResultM  out  32; RdM  out  5; RegWriteM  out  1  (forwarding/hazard taps).
REQ-008 SHALL have port: StallM  out  1  memory stage busy; hazard unit holds F/D/E.
REQ-009 SHALL have ports: dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32; dmem_be  out  4.
REQ-010 SHALL have ports: dmem_ready  in  1; dmem_rdata  in  32.
REQ-011 SHALL have ports: RegWriteW  out  1; ResultSrcW  out  2; RdW  out  5; ALUResultW, ReadDataW, PCPlus4W  out  32.
REQ-012 SHALL have ports: BusErrM, MisalignM  out  1  one-cycle error pulses.

Function
REQ-013 SHALL capture all E inputs into the EX/MEM register on each clk edge where StallM=0; SHALL hold it while StallM=1.
REQ-014 SHALL treat M as a memory op when MemWriteM=1 or ResultSrcM=01.
REQ-015 SHALL run FSM IDLE/WAIT: IDLE + memory op + dmem_ready=0 -> WAIT; WAIT + dmem_ready=1 -> IDLE; WAIT + counter reaching WAIT_MAX -> IDLE with BusErrM pulse.
REQ-016 SHALL assert dmem_req combinationally for the whole memory op, holding addr/wdata/be/we stable until the ready cycle.
REQ-017 SHALL set StallM = memory op && !dmem_ready && !timeout; zero-wait access completes in one cycle.
REQ-018 SHALL drive dmem_addr = {ALUResultM[31:2],2'b00}.
REQ-019 SHALL generate stores: SB be=0001<<a[1:0], byte replicated x4; SH be=0011<<(2*a[1]), half replicated x2; SW be=1111.
REQ-020 SHALL extract loads from dmem_rdata: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough, lane selected by a[1:0].
REQ-021 SHALL load the MEM/WB register on every clk edge: a bubble (RegWriteW=0) while StallM=1, otherwise M contents plus the aligned ReadData.
REQ-022 SHALL on bus error force RegWriteW=0 for that instruction and release the stall.
REQ-023 SHALL issue no dmem_req for funct3 011/110/111 and treat that op as a 1-cycle no-op with RegWriteW=0.
REQ-024 SHALL reset the wait counter on every transition into IDLE.

Reset
REQ-025 SHALL on rst_n=0, immediately and regardless of clk, clear both pipeline registers, counter and outputs to 0 and set FSM to IDLE.
REQ-026 SHALL on reset during WAIT abandon the access, with dmem_req=0 from the reset assertion onward.
REQ-027 SHALL leave the first edge after rst_n rises as a normal capture edge.

Configuration
REQ-028 SHALL, with MEM_MISALIGN_TRAP_EN defined, suppress dmem_req for misaligned accesses (H with a[0]=1, W with a[1:0]!=0), pulse MisalignM for one cycle and force RegWriteW=0.
REQ-029 SHALL, without MEM_MISALIGN_TRAP_EN, mask the offending low address bits to zero and tie MisalignM to 0.

Verification
REQ-030 SHALL cover: SW addr 0x100, data 0xDEADBEEF, ready=1 -> one req, be=1111, StallM=0, no bubble.
REQ-031 SHALL cover: LB addr 0x203, rdata 0x80FF7F01, ready after 3 cycles -> StallM=1 for 3 cycles, then ReadDataW=0xFFFFFF80 and RegWriteW=1.
REQ-032 SHALL cover: SH addr 0x12, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD.
REQ-033 SHALL cover: load with ready held 0, WAIT_MAX=15 -> BusErrM pulse on cycle 15, StallM then 0, RegWriteW=0.
REQ-034 SHALL cover: rst_n low in WAIT cycle 2 -> dmem_req=0 immediately; state IDLE and outputs 0 afterward.
REQ-035 SHALL cover: LW addr 0x102 -> with macro MisalignM=1 and no req; without macro dmem_addr=0x100 and the load completes.
